// File: rtl/adc_spi_init_pkg.sv
// rtl/adc_spi_init_pkg.sv - shared types and constants for the ADC SPI init sequencer
//
// Holds the sequencer state encoding, the default frame geometry and the
// ADC register addresses used to build the configuration table.

package adc_spi_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int DEF_NREG      = 8;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_WORD_BITS = 24;

  // ADC register addresses (13-bit register space)
  localparam logic [12:0] ADDR_CHIP_PWR  = 13'h008;
  localparam logic [12:0] ADDR_CLK_DIVID = 13'h009;
  localparam logic [12:0] ADDR_TEST_IO   = 13'h00D;
  localparam logic [12:0] ADDR_OUT_MODE  = 13'h014;
  localparam logic [12:0] ADDR_CLK_PHASE = 13'h016;
  localparam logic [12:0] ADDR_DCO_DELAY = 13'h017;
  localparam logic [12:0] ADDR_VREF      = 13'h018;
  localparam logic [12:0] ADDR_TRANSFER  = 13'h0FF;

  // Single-byte write frame: R/W=0, byte count W1:W0=00, address, data.
  function automatic logic [23:0] spi_write(input logic [12:0] addr, input logic [7:0] data);
    return {1'b0, 2'b00, addr, data};
  endfunction

endpackage

// File: rtl/adc_init_rom.sv
// rtl/adc_init_rom.sv - combinational ADC configuration table
//
// Ports:
//   i_addr : word index (WORD_IDX of the sequencer)
//   o_data : WORD_BITS-wide SPI frame for that index; zero beyond NREG-1

module adc_init_rom
  import adc_spi_init_pkg::*;
#(
  parameter  int NREG      = DEF_NREG,
  parameter  int WORD_BITS = DEF_WORD_BITS,
  localparam int IDX_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic [IDX_W-1:0]     i_addr,
  output logic [WORD_BITS-1:0] o_data
);

  logic [23:0] w_word;

  always_comb begin
    w_word = 24'h0;
    case (int'(i_addr))
      0:       w_word = spi_write(ADDR_CHIP_PWR,  8'h18);
      1:       w_word = spi_write(ADDR_OUT_MODE,  8'h01);
      2:       w_word = spi_write(ADDR_TEST_IO,   8'h00);
      3:       w_word = spi_write(ADDR_CLK_PHASE, 8'h00);
      4:       w_word = spi_write(ADDR_DCO_DELAY, 8'h00);
      5:       w_word = spi_write(ADDR_VREF,      8'h04);
      6:       w_word = spi_write(ADDR_CLK_DIVID, 8'h00);
      7:       w_word = spi_write(ADDR_TRANSFER,  8'h01);
      default: w_word = 24'h0;
    endcase
    if (int'(i_addr) >= NREG) w_word = 24'h0;
  end

  assign o_data = WORD_BITS'(w_word);

endmodule

// File: rtl/adc_spi_init.sv
// rtl/adc_spi_init.sv - SPI master that writes the ADC configuration table on request
//
// Ports:
//   CLK, RST_B  : system clock, asynchronous active-low reset
//   ADC_INIT    : level request for a full configuration pass
//   INIT_DONE   : all NREG words sent, held while ADC_INIT stays high
//   BUSY        : frame or inter-frame gap in progress
//   WORD_IDX    : index of the word being sent
//   ADC_SCLK, ADC_SDATA, ADC_CSB : SPI clock, data, active-low chip select
//
// Frame: SETUP (CLK_DIV) + WORD_BITS bits of 2*CLK_DIV + HOLD (CLK_DIV) + GAP (2*CLK_DIV).

module adc_spi_init
  import adc_spi_init_pkg::*;
#(
  parameter  int NREG      = DEF_NREG,
  parameter  int CLK_DIV   = DEF_CLK_DIV,
  parameter  int WORD_BITS = DEF_WORD_BITS,
  localparam int IDX_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             ADC_INIT,
  output logic             INIT_DONE,
  output logic             BUSY,
  output logic [IDX_W-1:0] WORD_IDX,
  output logic             ADC_SCLK,
  output logic             ADC_SDATA,
  output logic             ADC_CSB
);

  localparam int               BIT_W    = $clog2(WORD_BITS + 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREG - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_div;
  logic [BIT_W-1:0]     r_bit;
  logic [WORD_BITS-1:0] r_shift;
  logic                 r_sclk;
  logic [IDX_W-1:0]     r_word_idx;
  logic                 r_abort;

  logic                 w_phase_end;
  logic                 w_last_bit;
  logic                 w_gap_end;
  logic                 w_stop;
  logic                 w_cs_active;
  logic                 w_timed;
  logic [IDX_W-1:0]     w_rom_addr;
  logic [WORD_BITS-1:0] w_rom_data;

  assign w_timed     = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                       (r_state == ST_HOLD)  || (r_state == ST_GAP);
  assign w_cs_active = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
  assign w_phase_end = (r_div == DIV_LAST);
  // A bit ends on the falling SCLK edge, i.e. at the end of its high phase.
  assign w_last_bit  = (r_state == ST_SHIFT) && w_phase_end && r_sclk && (r_bit == BIT_LAST);
  // GAP is two divider phases, counted on the otherwise idle bit counter.
  assign w_gap_end   = (r_state == ST_GAP) && w_phase_end && (r_bit == BIT_W'(1));
  // A request dropped at any point in the frame ends the pass after this frame.
  assign w_stop      = r_abort || !ADC_INIT;
  // During GAP the table is pre-addressed with the next index so it can be loaded on exit.
  assign w_rom_addr  = (r_state == ST_GAP) ? r_word_idx + IDX_W'(1) : r_word_idx;

  adc_init_rom #(
    .NREG      (NREG),
    .WORD_BITS (WORD_BITS)
  ) u_rom (
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    INIT_DONE    = 1'b0;
    BUSY         = w_timed;
    ADC_CSB      = !w_cs_active;
    ADC_SCLK     = r_sclk;
    ADC_SDATA    = w_cs_active & r_shift[WORD_BITS-1];
    WORD_IDX     = r_word_idx;
    case (r_state)
      ST_IDLE:  if (ADC_INIT) w_next_state = ST_SETUP;
      ST_SETUP: if (w_phase_end) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last_bit) w_next_state = ST_HOLD;
      ST_HOLD:  if (w_phase_end) w_next_state = ST_GAP;
      ST_GAP: begin
        if (w_gap_end) begin
          if (w_stop)                         w_next_state = ST_IDLE;
          else if (r_word_idx == IDX_LAST)    w_next_state = ST_DONE;
          else                                w_next_state = ST_SETUP;
        end
      end
      ST_DONE: begin
        INIT_DONE = 1'b1;
        if (!ADC_INIT) w_next_state = ST_IDLE;
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_div      <= 8'd0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_sclk     <= 1'b0;
      r_word_idx <= '0;
      r_abort    <= 1'b0;
    end else begin
      if (w_timed) r_div <= w_phase_end ? 8'd0 : r_div + 8'd1;
      else         r_div <= 8'd0;

      case (r_state)
        ST_IDLE: if (ADC_INIT) r_shift <= w_rom_data;
        ST_SHIFT: begin
          if (w_phase_end) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
              r_bit   <= (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (w_phase_end) r_bit <= w_gap_end ? '0 : r_bit + 1'b1;
          if (w_next_state == ST_SETUP) begin
            r_shift    <= w_rom_data;
            r_word_idx <= r_word_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase

      if (r_state == ST_IDLE)         r_abort <= 1'b0;
      else if (w_timed && !ADC_INIT)  r_abort <= 1'b1;

      // Every pass starts from word 0, so the index is cleared on the way back to IDLE.
      if (w_next_state == ST_IDLE) r_word_idx <= '0;
    end
  end

endmodule

// File: doc/adc_spi_init.md
ADC_SPI_INIT -- requirements
Module: adc_spi_init

Interface
REQ-001 SHALL have parameter NREG, default 8, number of configuration words written per initialization.
REQ-002 SHALL have parameter CLK_DIV, default 4, SCLK half-period in CLK cycles (legal range 2..255).
REQ-003 SHALL have parameter WORD_BITS, default 24, bits per SPI frame (16 instruction/address + 8 data).
REQ-004 SHALL have port CLK, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST_B, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port ADC_INIT, input, 1, level request from the upstream ADC init FSM; high requests a full configuration pass.
REQ-007 SHALL have port INIT_DONE, output, 1, high once all NREG words are sent; consumed by the upstream FSM.
REQ-008 SHALL have port BUSY, output, 1, high whenever a frame or inter-frame gap is in progress.
REQ-009 SHALL have port WORD_IDX, output, ceil(log2(NREG)), index of the word being sent.
REQ-010 SHALL have ports ADC_SCLK, ADC_SDATA and ADC_CSB, outputs, 1 each, SPI clock, data and active-low chip select to the ADCs.

Function
REQ-011 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP and DONE.
REQ-012 IDLE: CSB=1, SCLK=0, SDATA=0, BUSY=0, INIT_DONE=0; ADC_INIT sampled high -> SETUP with WORD_IDX=0 and shift register loaded from the ROM; CSB low on the next cycle.
REQ-013 SETUP SHALL last CLK_DIV cycles with CSB=0 and SCLK=0, with SDATA already presenting the word MSB -> SHIFT.
REQ-014 SHIFT SHALL send WORD_BITS bits MSB first; each bit SHALL be SCLK low for CLK_DIV cycles then high for CLK_DIV cycles; SDATA SHALL change only on the SCLK falling edge (ADC samples on the rising edge).
REQ-015 After the last SCLK high phase, SCLK SHALL return low and the FSM SHALL go to HOLD, which lasts CLK_DIV cycles with CSB=0.
REQ-016 GAP SHALL last 2*CLK_DIV cycles with CSB=1; on exit, if WORD_IDX=NREG-1 -> DONE, else WORD_IDX+1, load the next word -> SETUP.
REQ-017 Frame timing SHALL be exactly 52*CLK_DIV cycles per word with the defaults (208); from ADC_INIT sampled high to INIT_DONE high SHALL be 1+NREG*208 = 1665 cycles.
REQ-018 DONE: INIT_DONE=1, BUSY=0, CSB=1; the block SHALL stay in DONE while ADC_INIT=1; on ADC_INIT=0 -> IDLE with INIT_DONE cleared the same cycle.
REQ-019 ADC_INIT falling in SETUP, SHIFT or HOLD SHALL NOT truncate the frame; the current frame completes, then GAP, then IDLE without asserting INIT_DONE.
REQ-020 ADC_INIT high again after an abort or DONE->IDLE SHALL restart from word 0; there is no partial resume.
REQ-021 The bit counter SHALL be ceil(log2(WORD_BITS+1)) wide and the divider counter 8 bits; neither counter SHALL wrap within a frame.

Reset
REQ-022 RST_B low SHALL force IDLE at any time, mid-frame included: CSB=1, SCLK=0, SDATA=0, INIT_DONE=0, BUSY=0, WORD_IDX=0, all counters 0.
REQ-023 After RST_B releases, the block SHALL NOT start until ADC_INIT is sampled high.

Structure
REQ-024 A shared package SHALL hold the state encoding, the default NREG, CLK_DIV and WORD_BITS, and the ADC register address constants.
REQ-025 The configuration table SHALL be a sub-module adc_init_rom (combinational, addressed by WORD_IDX, WORD_BITS wide); the FSM, divider and shifter SHALL be in adc_spi_init.

Verification
REQ-026 Reset, then ADC_INIT=1 held -> CSB falls 1 cycle later; 8 frames of 24 SCLK rising edges; INIT_DONE rises at cycle 1665.
REQ-027 ROM word 0 = 0x000818 -> SDATA sampled on SCLK rising edges decodes 0x000818 MSB first; SCLK period 8 CLK; CSB gap 8 CLK.
REQ-028 ADC_INIT dropped in word 3 at bit 10 -> word 3 completes all 24 bits; CSB high; INIT_DONE stays 0; IDLE after GAP.
REQ-029 RST_B low in the middle of SHIFT -> CSB=1 and SCLK=0 immediately (asynchronous); re-request sends from word 0.
REQ-030 In DONE, ADC_INIT dropped -> INIT_DONE=0 the next cycle; ADC_INIT high again -> a full 1665-cycle pass repeats.
REQ-031 Connected to the upstream ADC init FSM with its timeout at 5 slow ticks -> RUN asserts after INIT_DONE, and no timeout retry occurs.
